// File: rtl/audio_sdm_dac_pkg.sv
// Shared widths, field positions and the offset-binary helper for the stereo sigma-delta DAC.
package audio_sdm_dac_pkg;

  localparam int unsigned AUDIO_SAMPLE_W = 16;
  localparam int unsigned AUDIO_WORD_W   = 32;

  localparam logic [AUDIO_SAMPLE_W-1:0] AUDIO_MIDSCALE = 16'h0000;

  // Packed stereo word: left in the upper half, right in the lower half.
  localparam int unsigned AUDIO_L_LSB = 16;
  localparam int unsigned AUDIO_L_MSB = AUDIO_L_LSB + AUDIO_SAMPLE_W - 1;
  localparam int unsigned AUDIO_R_LSB = 0;
  localparam int unsigned AUDIO_R_MSB = AUDIO_R_LSB + AUDIO_SAMPLE_W - 1;

  // Two's complement to offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
  function automatic logic [AUDIO_SAMPLE_W-1:0] to_offset_binary(
    input logic [AUDIO_SAMPLE_W-1:0] s
  );
    return {~s[AUDIO_SAMPLE_W-1], s[AUDIO_SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/audio_sdm_channel.sv
// One channel of first-order sigma-delta modulation: the carry out of a 16-bit phase
// accumulator is the registered pulse-density bit.
module audio_sdm_channel
  import audio_sdm_dac_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AUDIO_SAMPLE_W-1:0] sample_i,
  output logic                      pdm_o
);

  logic [AUDIO_SAMPLE_W-1:0] u;
  logic [AUDIO_SAMPLE_W:0]   acc17;
  logic [AUDIO_SAMPLE_W-1:0] acc_q;
  logic                      pdm_q;

  always_comb begin
    u     = to_offset_binary(sample_i);
    acc17 = {1'b0, acc_q} + {1'b0, u};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc17[AUDIO_SAMPLE_W-1:0];
      pdm_q <= acc17[AUDIO_SAMPLE_W];
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/audio_sdm_dac.sv
// Stereo audio output stage: sample FIFO, sample-rate divider and two sigma-delta channels.
// Build option AUDIO_SDM_DAC_MUTE_ON_UNDERRUN_EN forces midscale on an underrun tick.
module audio_sdm_dac
  import audio_sdm_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 1134,
  parameter int unsigned FIFO_DEPTH_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sample_valid_i,
  input  logic [AUDIO_WORD_W-1:0] sample_data_i,
  output logic                    sample_accept_o,
  output logic                    audio_l_o,
  output logic                    audio_r_o,
  output logic                    underrun_o,
  output logic [FIFO_DEPTH_W:0]   fifo_level_o
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_W;
  localparam int unsigned CntW  = 16;

  localparam logic [CntW-1:0]         CntMax   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]         CntOne   = CntW'(1);
  localparam logic [FIFO_DEPTH_W-1:0] PtrOne   = FIFO_DEPTH_W'(1);
  localparam logic [FIFO_DEPTH_W:0]   LevelOne = (FIFO_DEPTH_W + 1)'(1);
  localparam logic [FIFO_DEPTH_W:0]   LevelMax = (FIFO_DEPTH_W + 1)'(Depth);

  // Sample-rate divider
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CntOne;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sample FIFO
  logic [AUDIO_WORD_W-1:0] mem_q [Depth];
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_W:0]   level_q, level_d;
  logic                    full, empty, push, pop;

  always_comb begin
    full     = (level_q == LevelMax);
    empty    = (level_q == '0);
    push     = sample_valid_i && !full;
    // A word pushed on an empty-FIFO tick is not visible yet; it waits for the next tick.
    pop      = tick && !empty;
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: the pointers and level alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Current sample registers
  logic [AUDIO_WORD_W-1:0]   head;
  logic [AUDIO_SAMPLE_W-1:0] cur_l_q, cur_l_d;
  logic [AUDIO_SAMPLE_W-1:0] cur_r_q, cur_r_d;

  always_comb begin
    head    = mem_q[rd_ptr_q];
    cur_l_d = cur_l_q;
    cur_r_d = cur_r_q;
    if (pop) begin
      cur_l_d = head[AUDIO_L_MSB:AUDIO_L_LSB];
      cur_r_d = head[AUDIO_R_MSB:AUDIO_R_LSB];
    end
`ifdef AUDIO_SDM_DAC_MUTE_ON_UNDERRUN_EN
    else if (tick) begin
      cur_l_d = AUDIO_MIDSCALE;
      cur_r_d = AUDIO_MIDSCALE;
    end
`else
    else begin
      cur_l_d = cur_l_q;
      cur_r_d = cur_r_q;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cur_l_q <= AUDIO_MIDSCALE;
      cur_r_q <= AUDIO_MIDSCALE;
    end else begin
      cur_l_q <= cur_l_d;
      cur_r_q <= cur_r_d;
    end
  end

  audio_sdm_channel u_chan_l (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sample_i (cur_l_q),
    .pdm_o    (audio_l_o)
  );

  audio_sdm_channel u_chan_r (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sample_i (cur_r_q),
    .pdm_o    (audio_r_o)
  );

  assign sample_accept_o = !full;
  assign underrun_o      = tick && empty;
  assign fifo_level_o    = level_q;

endmodule

// File: tb/tb_audio_sdm_dac.sv
// Directed bench for audio_sdm_dac with CLK_DIV=16 and an 8-entry FIFO; expected values are
// hand-derived from the divider phase and the exact ones-count of a constant-input modulator.
module tb_audio_sdm_dac;

  localparam int unsigned ClkDiv = 16;
  localparam int unsigned FifoW  = 3;

  logic              clk;
  logic              rst_n;
  logic              sample_valid;
  logic [31:0]       sample_data;
  logic              sample_accept;
  logic              audio_l;
  logic              audio_r;
  logic              underrun;
  logic [FifoW:0]    fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  audio_sdm_dac #(
    .CLK_DIV      (ClkDiv),
    .FIFO_DEPTH_W (FifoW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .sample_valid_i  (sample_valid),
    .sample_data_i   (sample_data),
    .sample_accept_o (sample_accept),
    .audio_l_o       (audio_l),
    .audio_r_o       (audio_r),
    .underrun_o      (underrun),
    .fifo_level_o    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  // Runs n cycles and counts output ones and underrun pulses seen.
  task automatic run_count(input int n, output int ones_l, output int ones_r, output int urs);
    ones_l = 0;
    ones_r = 0;
    urs    = 0;
    for (int i = 0; i < n; i++) begin
      step();
      ones_l += int'(audio_l);
      ones_r += int'(audio_r);
      urs    += int'(underrun);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  int ol, orr, ur;
  logic [31:0] word;

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    repeat (3) @(posedge clk);
    release_reset();

    // Idle: midscale alternates, underrun on every tick, FIFO stays empty.
    check_eq("rst_level", 32'(fifo_level), 0);
    check_eq("rst_accept", 32'(sample_accept), 1);
    check_eq("rst_underrun", 32'(underrun), 0);
    check_eq("rst_audio_l", 32'(audio_l), 0);
    check_eq("rst_audio_r", 32'(audio_r), 0);
    step();
    check_eq("mid_l_c1", 32'(audio_l), 0);
    step();
    check_eq("mid_l_c2", 32'(audio_l), 1);
    check_eq("mid_r_c2", 32'(audio_r), 1);
    step();
    check_eq("mid_l_c3", 32'(audio_l), 0);
    go_to(14);
    check_eq("no_tick_c14", 32'(underrun), 0);
    step();
    check_eq("first_tick_underrun", 32'(underrun), 1);
    step();
    check_eq("underrun_one_cycle", 32'(underrun), 0);
    run_count(48, ol, orr, ur);
    check_eq("idle_underruns", 32'(ur), 3);
    check_eq("idle_ones_l", 32'(ol), 24);
    check_eq("idle_ones_r", 32'(orr), 24);
    check_eq("idle_level", 32'(fifo_level), 0);

    // Full-scale left, minimum right.
    sample_valid = 1'b1;
    sample_data  = 32'h7FFF_8000;
    check_eq("push1_accept", 32'(sample_accept), 1);
    step();
    sample_valid = 1'b0;
    check_eq("push1_level", 32'(fifo_level), 1);
    go_to(79);
    check_eq("tick_nonempty_no_underrun", 32'(underrun), 0);
    step();
    check_eq("pop1_level", 32'(fifo_level), 0);
    run_count(16, ol, orr, ur);
    check_eq("fullscale_l_dense", 32'(ol >= 15), 1);
    check_eq("minscale_r_zero", 32'(orr), 0);

    // Fill to full: 8 accepted, 9th waits for the next pop.
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'h1000_0000 + 32'(i);
      step();
    end
    sample_data = 32'h1000_0008;
    check_eq("full_level", 32'(fifo_level), 8);
    check_eq("full_accept", 32'(sample_accept), 0);
    go_to(111);
    check_eq("full_tick_accept", 32'(sample_accept), 0);
    check_eq("full_tick_level", 32'(fifo_level), 8);
    step();
    check_eq("after_pop_level", 32'(fifo_level), 7);
    check_eq("after_pop_accept", 32'(sample_accept), 1);
    step();
    sample_valid = 1'b0;
    check_eq("ninth_level", 32'(fifo_level), 8);

    // Push coinciding with a tick at level 7.
    go_to(128);
    check_eq("level7", 32'(fifo_level), 7);
    go_to(143);
    sample_valid = 1'b1;
    sample_data  = 32'h2222_3333;
    check_eq("pushpop_accept_before", 32'(sample_accept), 1);
    step();
    sample_valid = 1'b0;
    check_eq("pushpop_level", 32'(fifo_level), 7);
    check_eq("pushpop_accept_after", 32'(sample_accept), 1);

    // Asynchronous reset mid-stream at level 5.
    go_to(176);
    check_eq("level5", 32'(fifo_level), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_level", 32'(fifo_level), 0);
    check_eq("async_rst_l", 32'(audio_l), 0);
    check_eq("async_rst_r", 32'(audio_r), 0);
    check_eq("async_rst_underrun", 32'(underrun), 0);
    repeat (2) @(posedge clk);
    release_reset();
    go_to(15);
    check_eq("post_rst_underrun", 32'(underrun), 1);
    check_eq("post_rst_level", 32'(fifo_level), 0);

    // Single word then drain: held or muted depending on the build.
    step();
    word         = 32'h4000_C000;
    sample_valid = 1'b1;
    sample_data  = word;
    step();
    sample_valid = 1'b0;
    go_to(32);
    check_eq("drain_pop_level", 32'(fifo_level), 0);
    run_count(16, ol, orr, ur);
    check_eq("q_l_ones", 32'(ol), 12);
    check_eq("q_r_ones", 32'(orr), 4);
    check_eq("drain_underrun1", 32'(ur), 1);
    run_count(16, ol, orr, ur);
`ifdef AUDIO_SDM_DAC_MUTE_ON_UNDERRUN_EN
    check_eq("muted_l_ones", 32'(ol), 8);
    check_eq("muted_r_ones", 32'(orr), 8);
`else
    check_eq("held_l_ones", 32'(ol), 12);
    check_eq("held_r_ones", 32'(orr), 4);
`endif
    check_eq("drain_underrun2", 32'(ur), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
